// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared widths, reset PC and fetch FSM encodings.
package pc_fetch_unit_pkg;
  localparam int DW = 32;
  localparam logic [DW-1:0] RESET_PC_DEF = 32'hBFC0_0000;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, PEND = 2'd2} fetch_state_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC priority select plus the PC+4 and branch-target adders.
module pc_next_mux
  import pc_fetch_unit_pkg::*;
(
  input  logic [DW-1:0] pcf,
  input  logic          branch_taken_d,
  input  logic [DW-1:0] sign_imm_d_shift2,
  input  logic [DW-1:0] pc_plus4_d,
  input  logic          jump_d,
  input  logic [DW-1:0] jump_target_d,
  input  logic          jr_d,
  input  logic [DW-1:0] jr_target_d,
  input  logic          exc_redirect,
  input  logic [DW-1:0] exc_pc,
  output logic [DW-1:0] pc_plus4_f,
  output logic [DW-1:0] pc_branch_d,
  output logic          d_redirect,
  output logic [DW-1:0] d_target,
  output logic [DW-1:0] next_pc
);
  assign pc_plus4_f  = pcf + 32'd4;
  assign pc_branch_d = pc_plus4_d + sign_imm_d_shift2;
  assign d_redirect  = jr_d | jump_d | branch_taken_d;
  assign d_target    = jr_d ? jr_target_d : jump_d ? jump_target_d : pc_branch_d;
  assign next_pc     = exc_redirect ? exc_pc : d_redirect ? d_target : pc_plus4_f;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC register, stall-time redirect holding and instruction SRAM request.
// Optional FETCH_ADEL_CHECK_EN flags misaligned fetch PCs and suppresses the SRAM request.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [DW-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          StallF,
  input  logic          BranchTakenD,
  input  logic [DW-1:0] SignImmD_shift2,
  input  logic [DW-1:0] PCPlus4D,
  input  logic          JumpD,
  input  logic [DW-1:0] JumpTargetD,
  input  logic          JrD,
  input  logic [DW-1:0] JrTargetD,
  input  logic          ExcRedirect,
  input  logic [DW-1:0] ExcPC,
  output logic [DW-1:0] PCF,
  output logic [DW-1:0] PCPlus4F,
  output logic [DW-1:0] PCBranchD,
  output logic          inst_sram_en,
  output logic [DW-1:0] inst_sram_addr,
  output logic          AdelF
);
  fetch_state_t state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, pend_q, pend_d;
  logic en_q, en_d;
  logic d_redirect;
  logic [DW-1:0] d_target, next_pc;

  pc_next_mux u_mux (
    .pcf(pc_q), .branch_taken_d(BranchTakenD), .sign_imm_d_shift2(SignImmD_shift2),
    .pc_plus4_d(PCPlus4D), .jump_d(JumpD), .jump_target_d(JumpTargetD), .jr_d(JrD),
    .jr_target_d(JrTargetD), .exc_redirect(ExcRedirect), .exc_pc(ExcPC),
    .pc_plus4_f(PCPlus4F), .pc_branch_d(PCBranchD), .d_redirect(d_redirect),
    .d_target(d_target), .next_pc(next_pc)
  );

  // Decode is frozen while stalled, so only the first redirect seen in RUN is captured.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    en_d    = en_q;
    if (state_q == BOOT) begin
      state_d = RUN;
      en_d    = 1'b1;
    end else if (ExcRedirect) begin
      pc_d    = ExcPC;
      pend_d  = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (!StallF) pc_d = next_pc;
      else if (d_redirect) begin
        pend_d  = d_target;
        state_d = PEND;
      end
    end else if (!StallF) begin
      pc_d    = pend_q;
      pend_d  = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
    end
  end

  assign PCF            = pc_q;
  assign inst_sram_addr = pc_q;
`ifdef FETCH_ADEL_CHECK_EN
  assign AdelF        = (pc_q[1:0] != 2'b00) && (state_q != BOOT);
  assign inst_sram_en = en_q & ~AdelF;
`else
  assign AdelF        = 1'b0;
  assign inst_sram_en = en_q;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a queued scoreboard checked by a separate monitor.
module tb_pc_fetch_unit;
  logic clock = 1'b0, reset = 1'b1;
  logic StallF = 0, BranchTakenD = 0, JumpD = 0, JrD = 0, ExcRedirect = 0;
  logic [31:0] SignImmD_shift2 = 0, PCPlus4D = 0, JumpTargetD = 0, JrTargetD = 0, ExcPC = 0;
  logic [31:0] PCF, PCPlus4F, PCBranchD, inst_sram_addr;
  logic inst_sram_en, AdelF;
  int checks = 0, failures = 0, step_id = 0;

  typedef struct {int id; logic [31:0] pc; logic en; logic adel;} exp_t;
  exp_t q[$];

`ifdef FETCH_ADEL_CHECK_EN
  localparam logic MIS_EN = 1'b0, MIS_ADEL = 1'b1;
`else
  localparam logic MIS_EN = 1'b1, MIS_ADEL = 1'b0;
`endif

  pc_fetch_unit dut (
    .clock(clock), .reset(reset), .StallF(StallF), .BranchTakenD(BranchTakenD),
    .SignImmD_shift2(SignImmD_shift2), .PCPlus4D(PCPlus4D), .JumpD(JumpD),
    .JumpTargetD(JumpTargetD), .JrD(JrD), .JrTargetD(JrTargetD), .ExcRedirect(ExcRedirect),
    .ExcPC(ExcPC), .PCF(PCF), .PCPlus4F(PCPlus4F), .PCBranchD(PCBranchD),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .AdelF(AdelF)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic br, input logic j, input logic jr,
                      input logic exc, input logic [31:0] imm, input logic [31:0] p4d,
                      input logic [31:0] jt, input logic [31:0] jrt, input logic [31:0] epc,
                      input logic [31:0] exp_pc, input logic exp_en, input logic exp_adel);
    exp_t e;
    @(negedge clock);
    reset = 0;
    StallF = st; BranchTakenD = br; JumpD = j; JrD = jr; ExcRedirect = exc;
    SignImmD_shift2 = imm; PCPlus4D = p4d; JumpTargetD = jt; JrTargetD = jrt; ExcPC = epc;
    e.id = step_id; e.pc = exp_pc; e.en = exp_en; e.adel = exp_adel;
    step_id++;
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] exp_pc);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp_pc, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    #2;
    checks++;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("step%0d_pcf", e.id), PCF, e.pc);
        chk($sformatf("step%0d_addr", e.id), inst_sram_addr, e.pc);
        chk($sformatf("step%0d_plus4", e.id), PCPlus4F, e.pc + 32'd4);
        chk($sformatf("step%0d_en", e.id), {31'd0, inst_sram_en}, {31'd0, e.en});
        chk($sformatf("step%0d_adel", e.id), {31'd0, AdelF}, {31'd0, e.adel});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #13;
    chk("rst_pcf", PCF, 32'hBFC00000);
    chk("rst_plus4", PCPlus4F, 32'hBFC00004);
    chk("rst_en", {31'd0, inst_sram_en}, 32'd0);
    chk("rst_adel", {31'd0, AdelF}, 32'd0);
    idle(32'hBFC00000);
    idle(32'hBFC00004);
    idle(32'hBFC00008);
    step(0, 1, 0, 0, 0, 32'hFFFFFFF0, 32'hBFC00010, 0, 0, 0, 32'hBFC00000, 1, 0);
    #1 chk("pcbranch_neg", PCBranchD, 32'hBFC00000);
    step(1, 0, 1, 0, 0, 0, 0, 32'hBFC00100, 0, 0, 32'hBFC00000, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0, 32'hBFC00200, 0, 0, 32'hBFC00000, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0, 32'hBFC00200, 0, 0, 32'hBFC00000, 1, 0);
    idle(32'hBFC00100);
    idle(32'hBFC00104);
    step(1, 0, 0, 1, 0, 0, 0, 0, 32'hBFC00500, 0, 32'hBFC00104, 1, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 32'hBFC00500, 32'hBFC00380, 32'hBFC00380, 1, 0);
    idle(32'hBFC00384);
    step(0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 1, 0);
    idle(32'h00000000);
    step(0, 0, 0, 1, 0, 0, 0, 0, 32'hBFC00002, 0, 32'hBFC00002, MIS_EN, MIS_ADEL);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC00006, MIS_EN, MIS_ADEL);
    step(0, 1, 0, 0, 0, 32'h00000020, 32'h00001000, 0, 0, 0, 32'h00001020, 1, 0);
    #1 chk("pcbranch_pos", PCBranchD, 32'h00001020);
    step(0, 1, 1, 0, 0, 32'h00000020, 32'h00001000, 32'h00002000, 0, 0, 32'h00002000, 1, 0);
    step(0, 1, 1, 1, 0, 32'h00000020, 32'h00001000, 32'h00002000, 32'h00003000, 0,
         32'h00003000, 1, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 32'h00003000, 32'hBFC00380, 32'hBFC00380, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0, 32'hBFC00700, 0, 0, 32'hBFC00380, 1, 0);
    drain();
    #1 reset = 1;
    #1;
    chk("async_rst_pcf", PCF, 32'hBFC00000);
    chk("async_rst_en", {31'd0, inst_sram_en}, 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hBFC00600, 32'hBFC00000, 1, 0);
    idle(32'hBFC00004);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Fetch-stage program-counter block of the myCPU pipeline. It consumes the decode-stage branch offset (sign-extended immediate already shifted left by 2) and forms the branch target against PCPlus4D. It arbitrates among exception, jump-register, jump, branch and sequential next-PC sources. It holds a redirect that arrives while fetch is stalled, and drives the instruction SRAM request.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- StallF  in  1  hold PCF this cycle
- BranchTakenD  in  1  decode branch resolved taken
- SignImmD_shift2  in  `DATALENGTH  branch offset (imm<<2)
- PCPlus4D  in  `DATALENGTH  PC+4 of branch in decode
- JumpD  in  1  J/JAL in decode
- JumpTargetD  in  `DATALENGTH  {PCPlus4D[31:28], instr_index, 2'b00}
- JrD  in  1  JR/JALR in decode
- JrTargetD  in  `DATALENGTH  forwarded rs value
- ExcRedirect  in  1  exception/ERET redirect (from mem stage)
- ExcPC  in  `DATALENGTH  exception vector or EPC
- PCF  out  `DATALENGTH  current fetch PC
- PCPlus4F  out  `DATALENGTH  PCF+4
- PCBranchD  out  `DATALENGTH  PCPlus4D+SignImmD_shift2 (combinational)
- inst_sram_en  out  1  fetch request
- inst_sram_addr  out  `DATALENGTH  equals PCF
- AdelF  out  1  misaligned fetch address flag

## Operation
- Redirect sources, priority high→low: ExcRedirect (ExcPC), JrD (JrTargetD), JumpD (JumpTargetD), BranchTakenD (PCBranchD), else PCPlus4F.
- All adds 32-bit modulo 2^32; carry discarded; 0xFFFF_FFFC+4 wraps to 0.
- FSM states:
  - BOOT: entered on reset; PCF=RESET_PC, inst_sram_en=0. Next cycle → RUN unconditionally.
  - RUN: inst_sram_en=1. Not stalled: PCF←selected next PC. Stalled with a D-stage redirect (jr/j/branch): latch target into pend_pc, stay stalled → PEND. Stalled, no redirect: hold.
  - PEND: inst_sram_en=1, PCF held. Entered with StallF already low: PCF←pend_pc → RUN. New D redirect while stalled: ignored; decode is frozen, first latched target kept.
- ExcRedirect in any state except BOOT: PCF←ExcPC next edge regardless of StallF. Clears pend_pc, forces RUN.
- ExcRedirect during BOOT ignored.
- Reset mid-operation: async, PCF=RESET_PC, state=BOOT, pend cleared immediately.

## Timing
- Reset values: PCF=RESET_PC, PCPlus4F=RESET_PC+4, inst_sram_en=0, AdelF=0, state=BOOT.
- Redirect latency: redirect condition sampled at edge N; PCF shows target after edge N (1 cycle). Delay-slot instruction is the one already in F at edge N, so no flush is generated here.
- PEND release: PCF←pend_pc on first edge with StallF=0.
- inst_sram_addr is PCF combinationally; SRAM data returns next cycle (sram timing, handled downstream).
- PCBranchD is purely combinational, zero latency.

## Configuration
- FETCH_ADEL_CHECK_EN defined: AdelF=(PCF[1:0]!=0)&&state!=BOOT, and inst_sram_en is forced 0 while AdelF=1 (no bus access on bad address).
- Not defined: AdelF tied 0; inst_sram_en follows FSM only.

## Structure
- defines.vh holds `DATALENGTH (31:0), RESET_PC default value, and FSM state encodings (BOOT/RUN/PEND, 2 bits).
- One sub-module: pc_next_mux. It is combinational priority select plus the PCBranchD and PCPlus4F adders. FSM and registers stay in pc_fetch_unit.

## Test plan
- Reset release → cycle 0 PCF=0xBFC00000, en=0; cycle 1 en=1; no stalls → PCF 0xBFC00004, 0xBFC00008 on successive edges.
- BranchTakenD=1, PCPlus4D=0xBFC00010, SignImmD_shift2=0xFFFFFFF0 → PCBranchD=0xBFC00000; PCF=0xBFC00000 after next edge.
- StallF=1 with JumpD=1, JumpTargetD=0xBFC00100 for 3 cycles → PCF held, state PEND; StallF=0 → PCF=0xBFC00100 next edge.
- ExcRedirect=1, ExcPC=0xBFC00380 same cycle as JrD=1 and StallF=1 → PCF=0xBFC00380, pend cleared, state RUN.
- JrTargetD=0xBFC00002 with FETCH_ADEL_CHECK_EN → after edge AdelF=1, inst_sram_en=0; without macro AdelF=0, en=1.
- Assert reset while in PEND → PCF=0xBFC00000 immediately (async), en=0, pending target discarded after release.
